// File: rtl/seven_seg_capture.sv
// Receive-side monitor for a multiplexed 7-segment bus: synchronises the scanned pins, waits for
// each dwell to settle, decodes the glyph back to hex and reports full-frame refreshes.
module seven_seg_capture #(
    parameter int unsigned SettleCycles = 4,
    parameter int unsigned SyncStages   = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  an_i,
    input  logic [6:0]  seg_i,
    input  logic        clr_err_i,
    output logic [31:0] digit_val_o,
    output logic [7:0]  digit_blank_o,
    output logic        frame_done_o,
    output logic        err_multi_o,
    output logic        err_pattern_o
);

    localparam int unsigned CntW = (SettleCycles < 2) ? 1 : $clog2(SettleCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(SettleCycles);
    localparam logic [CntW-1:0] CntCap = CntW'(SettleCycles - 1);

    logic [14:0]     sync_q [SyncStages];
    logic [14:0]     prev_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     val_q, val_d;
    logic [7:0]      blank_q, blank_d;
    logic [7:0]      seen_q, seen_d;
    logic            frame_q, frame_d;
    logic            multi_q, multi_d;
    logic            pat_q, pat_d;

    logic [14:0] cur;
    logic [7:0]  cur_an_low;
    logic [6:0]  cur_p;
    logic        stable;
    logic        capture;
    logic        one_hot;
    logic        many_low;
    logic [4:0]  dec;
    logic [7:0]  seen_next;
    logic        multi_set;
    logic        pat_set;

    // {valid, hex} for an active-high pattern (bit6 = a .. bit0 = g).
    function automatic logic [4:0] decode_glyph(input logic [6:0] p);
        logic [4:0] r;
        r = 5'b0;
        case (p)
            7'h7E:   r = {1'b1, 4'h0};
            7'h30:   r = {1'b1, 4'h1};
            7'h6D:   r = {1'b1, 4'h2};
            7'h79:   r = {1'b1, 4'h3};
            7'h33:   r = {1'b1, 4'h4};
            7'h5B:   r = {1'b1, 4'h5};
            7'h5F:   r = {1'b1, 4'h6};
            7'h70:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h7B:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h1F:   r = {1'b1, 4'hB};
            7'h4E:   r = {1'b1, 4'hC};
            7'h3D:   r = {1'b1, 4'hD};
            7'h4F:   r = {1'b1, 4'hE};
            7'h47:   r = {1'b1, 4'hF};
            default: r = 5'b0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < int'(SyncStages); k++) begin
                sync_q[k] <= '1;
            end
        end else begin
            sync_q[0] <= {an_i, seg_i};
            for (int k = 1; k < int'(SyncStages); k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign cur        = sync_q[SyncStages-1];
    assign cur_an_low = ~cur[14:7];
    assign cur_p      = ~cur[6:0];
    assign stable     = (cur == prev_q);
    assign one_hot    = (cur_an_low != 8'h00) && ((cur_an_low & (cur_an_low - 8'd1)) == 8'h00);
    assign many_low   = (cur_an_low != 8'h00) && !one_hot;
    assign dec        = decode_glyph(cur_p);

    // Saturation keeps cnt_d from revisiting CntCap, so one evaluation per dwell.
    always_comb begin
        cnt_d = '0;
        if (stable) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
        end
    end

    assign capture = (cnt_d == CntCap);

    always_comb begin
        val_d     = val_q;
        blank_d   = blank_q;
        seen_next = seen_q;
        multi_set = 1'b0;
        pat_set   = 1'b0;
        if (capture) begin
            if (many_low) begin
                multi_set = 1'b1;
            end else if (one_hot) begin
                for (int i = 0; i < 8; i++) begin
                    if (cur_an_low[i]) begin
                        if (dec[4]) begin
                            val_d[4*i +: 4] = dec[3:0];
                            blank_d[i]      = 1'b0;
                            seen_next[i]    = 1'b1;
                        end else if (cur_p == 7'h00) begin
                            val_d[4*i +: 4] = 4'h0;
                            blank_d[i]      = 1'b1;
                            seen_next[i]    = 1'b1;
                        end else begin
                            pat_set = 1'b1;
                        end
                    end
                end
            end
        end

        frame_d = 1'b0;
        seen_d  = seen_next;
        if (seen_next == 8'hFF) begin
            frame_d = 1'b1;
            seen_d  = 8'h00;
        end

        // A new error in the clearing cycle still sets the flag.
        multi_d = (multi_q && !clr_err_i) || multi_set;
        pat_d   = (pat_q && !clr_err_i) || pat_set;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q  <= '1;
            cnt_q   <= '0;
            val_q   <= '0;
            blank_q <= 8'hFF;
            seen_q  <= '0;
            frame_q <= 1'b0;
            multi_q <= 1'b0;
            pat_q   <= 1'b0;
        end else begin
            prev_q  <= cur;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            blank_q <= blank_d;
            seen_q  <= seen_d;
            frame_q <= frame_d;
            multi_q <= multi_d;
            pat_q   <= pat_d;
        end
    end

    assign digit_val_o   = val_q;
    assign digit_blank_o = blank_q;
    assign frame_done_o  = frame_q;
    assign err_multi_o   = multi_q;
    assign err_pattern_o = pat_q;

endmodule
